fc_wr_ctrl: RTL and testbench
=============================

// Module: fc_wr_ctrl
// PURPOSE
//   Write-back stage downstream of the fully-connect layer. Captures one result tile
//   [batch_size][bias_size] of 32-bit words and gets a base address from fc_ctrl.
//   Writes the tile to the bus in bursts of up to 16 beats, then signals fc_ctrl.
// PARAMETERS
//   batch_size  1        rows of the result tile
//   bias_size   1        columns of the result tile (one per output neuron)
//   word_len    32       bus word width in bits; address stride per beat is 32/word_len
//   AWID        4'b1010  write id driven on awuserid and matched on bid
// PORTS
//   clk                 in   1    clock, rising edge
//   rst                 in   1    asynchronous, active-high reset
//   FcNwc_result        in   [batch_size-1:0][bias_size-1:0][31:0]  result tile
//   FcNwc_result_valid  in   1    tile valid; held by producer until accepted
//   NwcFc_result_ready  out  1    block idle, able to accept a tile
//   NwcBus_awvalid      out  1    write address valid
//   NwcBus_awuserid     out  4    write id (= AWID)
//   NwcBus_awlen        out  4    beats-1 of the current burst
//   NwcBus_awaddr       out  28   burst start address
//   BusNwc_awready      in   1    address accepted
//   NwcBus_wvalid       out  1    write data valid
//   NwcBus_wdata        out  32   write data
//   NwcBus_wlast        out  1    last beat of the burst
//   BusNwc_wready       in   1    beat accepted
//   BusNwc_bvalid       in   1    write response valid
//   BusNwc_bid          in   4    response id
//   NwcBus_bready       out  1    response ready
//   NcNwc_initAddr      in   28   base address of the tile
//   NcNwc_initAddrEn    in   1    initAddr valid
//   NwcNc_initAddrRq    out  1    request base address
//   NwcNc_wr_end        out  1    one-cycle pulse: whole tile written
// BEHAVIOUR
//   - Tile size and word order:
//     - RESULT_SIZE = batch_size*bias_size.
//     - Flat index i = b*bias_size+k; beats are sent in increasing i.
//     - Word 0 is [0][0].
//   - Reset: all outputs 0; state IDLE; buffer, counters and address cleared.
//     - Reset mid-operation aborts at once; no wr_end.
//   - State machine, all outputs registered:
//     - IDLE: ready=1.
//       - valid&ready at an edge: capture tile, ready->0 next cycle, go ADDR_RQ.
//     - ADDR_RQ: initAddrRq=1.
//       - On initAddrEn: latch initAddr, Rq->0, go AW.
//     - AW: awvalid=1, awuserid=AWID, awaddr=cur_addr.
//       - awlen = min(16,remaining)-1.
//       - Fields stay stable until awready; awready in the first awvalid cycle completes.
//       - awvalid->0, go W.
//     - W: wvalid=1, wdata=buf[idx], wlast=1 on the burst's final beat.
//       - Each wvalid&wready advances idx; wready low holds wdata and wlast stable.
//       - After the last beat: wvalid->0, go B.
//     - B: bready=1.
//       - bvalid with bid==AWID: cur_addr += beats*(32/word_len).
//       - If remaining==0 go DONE, else go AW.
//       - bvalid with any other bid is ignored.
//     - DONE: wr_end=1 for exactly one cycle, then IDLE.
//   - Latency, RESULT_SIZE<=16, zero-wait bus: tile accept -> wr_end in RESULT_SIZE+5 cycles.
//     - This excludes ADDR_RQ wait cycles.
//   - Boundary conditions:
//     - RESULT_SIZE=16: one burst, awlen=15.
//     - RESULT_SIZE=17: bursts of 16 and 1 (awlen 15, 0).
//     - Final partial burst: wlast on beat (remaining-1).
//     - initAddrEn outside ADDR_RQ is ignored.
//     - result_valid while not IDLE is ignored; the producer must hold.
//     - Address wraps modulo 2^28 with no error.
//     - No bus write is ever issued before the address handshake completes.
// STRUCTURE
//   - fc_pkg holds:
//     - state enum
//     - ARID/AWID constants
//     - BURST_LEN=16
//     - ADDR_W=28
//     - bus id width
//   - Single module, no sub-module.
//   - Tile buffer: flat [RESULT_SIZE-1:0][31:0] register.
//   - Counters: idx, beat and remaining, each $clog2(RESULT_SIZE+1) bits.
// TESTING
//   1. b=1,k=4, tile {1,2,3,4}, initAddr=0x100, zero-wait bus.
//      -> awaddr 0x100, awlen 3, wdata 1,2,3,4, wlast on 4, wr_end once.
//   2. b=2,k=9 (18 words), initAddr=0x200.
//      -> bursts at 0x200 (awlen 15) and 0x210 (awlen 1); words in i order; one wr_end.
//   3. wready toggled 1,0,0,1 each beat.
//      -> wdata/wlast stable while stalled; beat count exact; no dropped beat.
//   4. bvalid with bid=4'b1001 first, then 4'b1010.
//      -> first ignored; state advances only on the second.
//   5. rst pulsed high mid-W.
//      -> all outputs 0 next edge, no wr_end; a new tile afterwards writes correctly.
//   6. result_valid held high through a transfer with changing data.
//      -> only the first tile is captured; ready=0 until return to IDLE.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and constants for the FC write-back path.
package fc_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_RQ,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } fc_wr_state_e;

    localparam int              BURST_LEN = 16;
    localparam int              ADDR_W    = 28;
    localparam int              ID_W      = 4;
    localparam logic [ID_W-1:0] FC_ARID   = 4'b0101;
    localparam logic [ID_W-1:0] FC_AWID   = 4'b1010;

    // awlen for the next burst: min(BURST_LEN, remaining) - 1
    function automatic logic [3:0] burst_m1(input int remaining);
        return (remaining >= BURST_LEN) ? 4'(BURST_LEN - 1) : 4'(remaining - 1);
    endfunction
endpackage

// File: rtl/fc_wr_ctrl_if.sv
// Write-channel bus (address, data, response) between the write-back stage and the memory bus.
interface fc_wr_ctrl_if;
    import fc_pkg::*;

    logic              awvalid;
    logic [ID_W-1:0]   awuserid;
    logic [3:0]        awlen;
    logic [ADDR_W-1:0] awaddr;
    logic              awready;
    logic              wvalid;
    logic [31:0]       wdata;
    logic              wlast;
    logic              wready;
    logic              bvalid;
    logic [ID_W-1:0]   bid;
    logic              bready;

    modport master (
        output awvalid, awuserid, awlen, awaddr, input awready,
        output wvalid, wdata, wlast, input wready,
        input bvalid, bid, output bready
    );

    modport slave (
        input awvalid, awuserid, awlen, awaddr, output awready,
        input wvalid, wdata, wlast, output wready,
        output bvalid, bid, input bready
    );
endinterface

// File: rtl/fc_wr_ctrl.sv
// Buffers one FC result tile and writes it to the bus in bursts of up to
// BURST_LEN beats starting at a base address supplied by fc_ctrl.
module fc_wr_ctrl
    import fc_pkg::*;
#(
    parameter int              batch_size = 1,
    parameter int              bias_size  = 1,
    parameter int              word_len   = 32,
    parameter logic [ID_W-1:0] AWID       = FC_AWID
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [batch_size-1:0][bias_size-1:0][31:0] FcNwc_result,
    input  logic                                    FcNwc_result_valid,
    output logic                                    NwcFc_result_ready,
    fc_wr_ctrl_if.master                            bus,
    input  logic [ADDR_W-1:0]                       NcNwc_initAddr,
    input  logic                                    NcNwc_initAddrEn,
    output logic                                    NwcNc_initAddrRq,
    output logic                                    NwcNc_wr_end
);
    localparam int RESULT_SIZE = batch_size * bias_size;
    localparam int CW          = $clog2(RESULT_SIZE + 1);
    localparam int STRIDE      = 32 / word_len;

    fc_wr_state_e                 state_q, state_d;
    logic [RESULT_SIZE-1:0][31:0] buf_q;
    logic [CW-1:0]                idx_q, idx_d, beat_q, beat_d, rem_q, rem_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [3:0]                   awlen_q, awlen_d;
    logic [31:0]                  wdata_q, wdata_d;
    logic ready_q, ready_d, rq_q, rq_d, awvalid_q, awvalid_d;
    logic wvalid_q, wvalid_d, wlast_q, wlast_d, bready_q, bready_d;
    logic wr_end_q, wr_end_d, cap;

    // Mux by comparison so the counter width need not match the buffer index width.
    function automatic logic [31:0] word_at(input logic [RESULT_SIZE-1:0][31:0] tile,
                                            input logic [CW-1:0] i);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < RESULT_SIZE; j++)
            if (CW'(j) == i) w = tile[j];
        return w;
    endfunction

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        rq_d      = rq_q;
        awvalid_d = awvalid_q;
        awlen_d   = awlen_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        wr_end_d  = 1'b0;
        addr_d    = addr_q;
        idx_d     = idx_q;
        beat_d    = beat_q;
        rem_d     = rem_q;
        cap       = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (FcNwc_result_valid && ready_q) begin
                    cap     = 1'b1;
                    ready_d = 1'b0;
                    rq_d    = 1'b1;
                    rem_d   = CW'(RESULT_SIZE);
                    idx_d   = '0;
                    state_d = S_ADDR_RQ;
                end
            end
            S_ADDR_RQ: begin
                if (NcNwc_initAddrEn) begin
                    addr_d    = NcNwc_initAddr;
                    rq_d      = 1'b0;
                    awvalid_d = 1'b1;
                    awlen_d   = burst_m1(int'(rem_q));
                    state_d   = S_AW;
                end
            end
            S_AW: begin
                if (bus.awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wdata_d   = word_at(buf_q, idx_q);
                    wlast_d   = (awlen_q == 4'd0);
                    beat_d    = '0;
                    state_d   = S_W;
                end
            end
            S_W: begin
                if (bus.wready) begin
                    idx_d = idx_q + 1'b1;
                    if (int'(beat_q) == int'(awlen_q)) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        wdata_d  = '0;
                        bready_d = 1'b1;
                        rem_d    = rem_q - CW'(int'(awlen_q) + 1);
                        state_d  = S_B;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        wdata_d = word_at(buf_q, idx_d);
                        wlast_d = (int'(beat_q) + 1 == int'(awlen_q));
                    end
                end
            end
            S_B: begin
                // Responses for other ids belong to other masters; keep waiting.
                if (bus.bvalid && bus.bid == AWID) begin
                    bready_d = 1'b0;
                    addr_d   = addr_q + ADDR_W'((int'(awlen_q) + 1) * STRIDE);
                    if (rem_q == '0) begin
                        wr_end_d = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        awvalid_d = 1'b1;
                        awlen_d   = burst_m1(int'(rem_q));
                        state_d   = S_AW;
                    end
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            idx_q     <= '0;
            beat_q    <= '0;
            rem_q     <= '0;
            addr_q    <= '0;
            awlen_q   <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            rq_q      <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            wr_end_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (cap) buf_q <= FcNwc_result;
            idx_q     <= idx_d;
            beat_q    <= beat_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            awlen_q   <= awlen_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            rq_q      <= rq_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            wr_end_q  <= wr_end_d;
        end
    end

    assign NwcFc_result_ready = ready_q;
    assign NwcNc_initAddrRq   = rq_q;
    assign NwcNc_wr_end       = wr_end_q;
    assign bus.awvalid        = awvalid_q;
    assign bus.awuserid       = awvalid_q ? AWID : '0;
    assign bus.awlen          = awlen_q;
    assign bus.awaddr         = addr_q;
    assign bus.wvalid         = wvalid_q;
    assign bus.wdata          = wdata_q;
    assign bus.wlast          = wlast_q;
    assign bus.bready         = bready_q;
endmodule

// File: tb/tb_fc_wr_ctrl.sv
// Scoreboard bench: two instances (1x4 and 2x9 tiles) driven by directed tiles.
module tb_fc_wr_ctrl;
    import fc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // DUT-facing arrays, index 0 = 1x4 instance, index 1 = 2x9 instance
    logic        rst_i [2]     = '{1'b1, 1'b1};
    logic        valid_i [2]   = '{1'b0, 1'b0};
    logic [31:0] tile_i [2][18];
    logic        awready_i [2] = '{1'b1, 1'b1};
    logic        wready_i [2]  = '{1'b1, 1'b1};
    logic        bvalid_i [2]  = '{1'b0, 1'b0};
    logic [3:0]  bid_i [2]     = '{4'd0, 4'd0};
    logic [27:0] addr_i [2]    = '{28'd0, 28'd0};
    logic        addren_i [2]  = '{1'b0, 1'b0};

    logic        ready_m [2], rq_m [2], end_m [2];
    logic        awvalid_m [2], wvalid_m [2], wlast_m [2], bready_m [2];
    logic [3:0]  awlen_m [2], awid_m [2];
    logic [27:0] awaddr_m [2];
    logic [31:0] wdata_m [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int B = (g == 0) ? 1 : 2;
        localparam int K = (g == 0) ? 4 : 9;
        fc_wr_ctrl_if bus ();
        logic [B-1:0][K-1:0][31:0] res;
        for (genvar i = 0; i < B * K; i++) begin : g_res
            assign res[i / K][i % K] = tile_i[g][i];
        end
        assign bus.awready  = awready_i[g];
        assign bus.wready   = wready_i[g];
        assign bus.bvalid   = bvalid_i[g];
        assign bus.bid      = bid_i[g];
        assign awvalid_m[g] = bus.awvalid;
        assign awid_m[g]    = bus.awuserid;
        assign awlen_m[g]   = bus.awlen;
        assign awaddr_m[g]  = bus.awaddr;
        assign wvalid_m[g]  = bus.wvalid;
        assign wdata_m[g]   = bus.wdata;
        assign wlast_m[g]   = bus.wlast;
        assign bready_m[g]  = bus.bready;
        fc_wr_ctrl #(.batch_size(B), .bias_size(K), .word_len(32), .AWID(FC_AWID)) dut (
            .clk(clk), .rst(rst_i[g]),
            .FcNwc_result(res), .FcNwc_result_valid(valid_i[g]), .NwcFc_result_ready(ready_m[g]),
            .bus(bus.master),
            .NcNwc_initAddr(addr_i[g]), .NcNwc_initAddrEn(addren_i[g]),
            .NwcNc_initAddrRq(rq_m[g]), .NwcNc_wr_end(end_m[g])
        );
    end

    // scoreboard: aw entries {addr,len}, w entries {last,data}
    logic [31:0] exp_aw [2][$];
    logic [32:0] exp_w [2][$];
    int   rs [2] = '{4, 18};
    int   ends [2] = '{0, 0};
    int   acc_cyc [2] = '{0, 0};
    int   cyc = 0;
    bit   busy [2], aw_seen [2], prev_stall [2], prev_badb [2], lat_chk [2];
    bit   stall_mode [2], bad_bid_pend [2], spurious [2];
    logic [31:0] pw_data [2];
    logic        pw_last [2];
    logic [27:0] base_i [2];
    logic [3:0]  wpat = 4'b1001;
    int   wcyc [2] = '{0, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // bus slave and fc_ctrl model, updated just after each rising edge
    initial begin : resp
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                awready_i[d] = 1'b1;
                if (wvalid_m[d] && stall_mode[d]) begin
                    wready_i[d] = wpat[wcyc[d]];
                    wcyc[d] = (wcyc[d] + 1) % 4;
                end else wready_i[d] = 1'b1;
                bvalid_i[d] = bready_m[d];
                if (bready_m[d] && bad_bid_pend[d]) begin
                    bid_i[d] = 4'b1001;
                    bad_bid_pend[d] = 1'b0;
                end else bid_i[d] = FC_AWID;
                addren_i[d] = rq_m[d] || spurious[d];
                addr_i[d] = rq_m[d] ? base_i[d] : 28'hBAD0BAD;
            end
        end
    end

    initial begin : mon
        logic [31:0] ea;
        logic [32:0] ew;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rst_i[d]) begin
                    prev_stall[d] = 1'b0;
                    prev_badb[d] = 1'b0;
                end else begin
                    if (valid_i[d] && ready_m[d]) begin
                        busy[d] = 1'b1;
                        acc_cyc[d] = cyc;
                        aw_seen[d] = 1'b0;
                    end else if (busy[d]) chk("ready_low_while_busy", 64'(ready_m[d]), 64'(0));
                    if (prev_stall[d]) begin
                        chk("wdata_stable_stall", 64'(wdata_m[d]), 64'(pw_data[d]));
                        chk("wlast_stable_stall", 64'(wlast_m[d]), 64'(pw_last[d]));
                        chk("wvalid_held_stall", 64'(wvalid_m[d]), 64'(1));
                    end
                    if (prev_badb[d]) chk("bready_after_bad_bid", 64'(bready_m[d]), 64'(1));
                    if (wvalid_m[d]) chk("w_after_aw", 64'(aw_seen[d]), 64'(1));
                    if (awvalid_m[d] && awready_i[d]) begin
                        aw_seen[d] = 1'b1;
                        chk("aw_expected", 64'(exp_aw[d].size() != 0), 64'(1));
                        if (exp_aw[d].size() != 0) begin
                            ea = exp_aw[d].pop_front();
                            chk("awaddr", 64'(awaddr_m[d]), 64'(ea[31:4]));
                            chk("awlen", 64'(awlen_m[d]), 64'(ea[3:0]));
                            chk("awuserid", 64'(awid_m[d]), 64'(FC_AWID));
                        end
                    end
                    if (wvalid_m[d] && wready_i[d]) begin
                        chk("w_expected", 64'(exp_w[d].size() != 0), 64'(1));
                        if (exp_w[d].size() != 0) begin
                            ew = exp_w[d].pop_front();
                            chk("wdata", 64'(wdata_m[d]), 64'(ew[31:0]));
                            chk("wlast", 64'(wlast_m[d]), 64'(ew[32]));
                        end
                    end
                    if (bvalid_i[d] && bready_m[d] && bid_i[d] == FC_AWID) aw_seen[d] = 1'b0;
                    prev_stall[d] = wvalid_m[d] && !wready_i[d];
                    pw_data[d] = wdata_m[d];
                    pw_last[d] = wlast_m[d];
                    prev_badb[d] = bvalid_i[d] && bready_m[d] && (bid_i[d] != FC_AWID);
                    if (end_m[d]) begin
                        ends[d]++;
                        busy[d] = 1'b0;
                        if (lat_chk[d])
                            chk("latency_within_bound", 64'((cyc - acc_cyc[d]) <= rs[d] + 5), 64'(1));
                        chk("queues_drained_at_end", 64'(exp_aw[d].size() + exp_w[d].size()), 64'(0));
                    end
                end
            end
        end
    end

    task automatic push_aw(input int d, input logic [27:0] a, input logic [3:0] l);
        exp_aw[d].push_back({a, l});
    endtask

    task automatic push_w(input int d, input logic [31:0] w, input logic last);
        exp_w[d].push_back({last, w});
    endtask

    task automatic send(input int d, input logic [27:0] base);
        base_i[d] = base;
        @(posedge clk);
        #1;
        valid_i[d] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (busy[d]) break;
        end
        chk("tile_accepted", 64'(busy[d]), 64'(1));
        valid_i[d] = 1'b0;
    endtask

    task automatic wait_end(input int d, input int exp, input int budget);
        for (int k = 0; k < budget && ends[d] < exp; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("wr_end_count", 64'(ends[d]), 64'(exp));
        chk("idle_ready_after_end", 64'(ready_m[d]), 64'(1));
    endtask

    initial begin : main
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 18; i++) tile_i[d][i] = '0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 64'(ready_m[d]), 64'(0));
            chk("rst_rq", 64'(rq_m[d]), 64'(0));
            chk("rst_awvalid", 64'(awvalid_m[d]), 64'(0));
            chk("rst_wvalid", 64'(wvalid_m[d]), 64'(0));
            chk("rst_bready", 64'(bready_m[d]), 64'(0));
            chk("rst_wr_end", 64'(end_m[d]), 64'(0));
        end
        rst_i[0] = 1'b0;
        rst_i[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(ready_m[0]), 64'(1));

        // 1: 1x4 tile at 0x100, zero-wait bus
        lat_chk[0] = 1'b1;
        for (int i = 0; i < 4; i++) tile_i[0][i] = 32'(i + 1);
        push_aw(0, 28'h100, 4'd3);
        for (int i = 0; i < 4; i++) push_w(0, 32'(i + 1), i == 3);
        send(0, 28'h100);
        wait_end(0, 1, 60);

        // 2: 2x9 tile, bursts of 16 + 2
        for (int i = 0; i < 18; i++) tile_i[1][i] = 32'h1000 + 32'(i);
        push_aw(1, 28'h200, 4'd15);
        push_aw(1, 28'h210, 4'd1);
        for (int i = 0; i < 18; i++) push_w(1, 32'h1000 + 32'(i), (i == 15) || (i == 17));
        send(1, 28'h200);
        wait_end(1, 1, 100);

        // 2b: second burst address wraps past 2^28
        for (int i = 0; i < 18; i++) tile_i[1][i] = 32'h2000 + 32'(i);
        push_aw(1, 28'hFFFFFF8, 4'd15);
        push_aw(1, 28'h0000008, 4'd1);
        for (int i = 0; i < 18; i++) push_w(1, 32'h2000 + 32'(i), (i == 15) || (i == 17));
        send(1, 28'hFFFFFF8);
        wait_end(1, 2, 100);

        // 3: wready pattern 1,0,0,1
        lat_chk[0] = 1'b0;
        stall_mode[0] = 1'b1;
        wcyc[0] = 0;
        for (int i = 0; i < 4; i++) tile_i[0][i] = 32'hA1 + 32'(i);
        push_aw(0, 28'h300, 4'd3);
        for (int i = 0; i < 4; i++) push_w(0, 32'hA1 + 32'(i), i == 3);
        send(0, 28'h300);
        wait_end(0, 2, 80);
        stall_mode[0] = 1'b0;

        // 4: foreign bid first, then own id
        bad_bid_pend[0] = 1'b1;
        for (int i = 0; i < 4; i++) tile_i[0][i] = 32'hB1 + 32'(i);
        push_aw(0, 28'h400, 4'd3);
        for (int i = 0; i < 4; i++) push_w(0, 32'hB1 + 32'(i), i == 3);
        send(0, 28'h400);
        wait_end(0, 3, 60);

        // 5: reset mid-W, then a fresh tile
        for (int i = 0; i < 4; i++) tile_i[0][i] = 32'h51 + 32'(i);
        push_aw(0, 28'h500, 4'd3);
        for (int i = 0; i < 4; i++) push_w(0, 32'h51 + 32'(i), i == 3);
        send(0, 28'h500);
        for (int k = 0; k < 40 && !wvalid_m[0]; k++) @(negedge clk);
        chk("w_phase_reached", 64'(wvalid_m[0]), 64'(1));
        @(negedge clk);
        rst_i[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("midw_rst_ready", 64'(ready_m[0]), 64'(0));
        chk("midw_rst_awvalid", 64'(awvalid_m[0]), 64'(0));
        chk("midw_rst_awaddr", 64'(awaddr_m[0]), 64'(0));
        chk("midw_rst_awlen", 64'(awlen_m[0]), 64'(0));
        chk("midw_rst_wvalid", 64'(wvalid_m[0]), 64'(0));
        chk("midw_rst_wdata", 64'(wdata_m[0]), 64'(0));
        chk("midw_rst_wlast", 64'(wlast_m[0]), 64'(0));
        chk("midw_rst_bready", 64'(bready_m[0]), 64'(0));
        chk("midw_rst_wr_end", 64'(end_m[0]), 64'(0));
        exp_aw[0].delete();
        exp_w[0].delete();
        busy[0] = 1'b0;
        @(negedge clk);
        rst_i[0] = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) tile_i[0][i] = 32'h61 + 32'(i);
        push_aw(0, 28'h600, 4'd3);
        for (int i = 0; i < 4; i++) push_w(0, 32'h61 + 32'(i), i == 3);
        send(0, 28'h600);
        wait_end(0, 4, 60);

        // 6: valid held with changing data, stray initAddrEn outside ADDR_RQ
        lat_chk[0] = 1'b1;
        spurious[0] = 1'b1;
        for (int i = 0; i < 4; i++) tile_i[0][i] = 32'h71 + 32'(i);
        push_aw(0, 28'h700, 4'd3);
        for (int i = 0; i < 4; i++) push_w(0, 32'h71 + 32'(i), i == 3);
        base_i[0] = 28'h700;
        @(posedge clk);
        #1;
        valid_i[0] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (end_m[0]) break;
            if (!ready_m[0])
                for (int i = 0; i < 4; i++) tile_i[0][i] = 32'hDEAD0000 + 32'(k * 4 + i);
        end
        valid_i[0] = 1'b0;
        spurious[0] = 1'b0;
        wait_end(0, 5, 20);
        chk("no_recapture_rq", 64'(rq_m[0]), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
